// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: instruction fetch vs load/store,
// with range/funct3 checking, a fetch starvation guard and registered memory strobes.
module mem_arbiter #(
  parameter int unsigned MEMSIZE  = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        if_req_valid_i,
  output logic        if_req_ready_o,
  input  logic [31:0] if_req_addr_i,
  output logic        if_rsp_valid_o,
  input  logic        if_rsp_ready_i,
  output logic [31:0] if_rsp_data_o,
  output logic        if_rsp_err_o,

  input  logic        ls_req_valid_i,
  output logic        ls_req_ready_o,
  input  logic        ls_req_write_i,
  input  logic [31:0] ls_req_addr_i,
  input  logic [11:0] ls_req_offset_i,
  input  logic [2:0]  ls_req_funct3_i,
  input  logic [31:0] ls_req_wdata_i,
  output logic        ls_rsp_valid_o,
  input  logic        ls_rsp_ready_i,
  output logic [31:0] ls_rsp_data_o,
  output logic        ls_rsp_err_o,

  output logic [31:0] mem_addr_o,
  output logic [11:0] mem_offset_o,
  output logic [31:0] mem_value_o,
  output logic [2:0]  mem_funct3_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  localparam logic [3:0]  MaxWait = 4'(MAX_WAIT);
  localparam logic [32:0] MemSize = 33'(MEMSIZE);

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [31:0] eff_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  funct3_q;
  logic        write_q;
  logic        owner_if_q;
  logic        err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        if_rsp_valid_q;
  logic        ls_rsp_valid_q;

  logic [31:0] ls_eff;
  logic [2:0]  ls_size;
  logic        ls_f3_bad;
  logic        ls_range_bad;
  logic        if_range_bad;
  logic        if_win;
  logic        ls_win;
  logic        idle;
  logic        rsp_ready;

  logic [31:0] sel_eff;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_funct3;
  logic        sel_write;
  logic        sel_err;

  // Request decode: effective address, access size and error flags.
  always_comb begin
    ls_eff    = ls_req_addr_i + {{20{ls_req_offset_i[11]}}, ls_req_offset_i};
    ls_size   = 3'd0;
    ls_f3_bad = 1'b0;
    case (ls_req_funct3_i)
      3'd0, 3'd4: ls_size = 3'd1;
      3'd1, 3'd5: ls_size = 3'd2;
      3'd2:       ls_size = 3'd4;
      default:    ls_f3_bad = 1'b1;
    endcase
    // Unsigned load variants have no store counterpart.
    if (ls_req_write_i && ls_req_funct3_i[2]) ls_f3_bad = 1'b1;
    // 33-bit sums so an address near 2^32 cannot wrap back into range.
    ls_range_bad = ({1'b0, ls_eff} + 33'(ls_size)) > MemSize;
    if_range_bad = ({1'b0, if_req_addr_i} + 33'd4) > MemSize;
  end

  assign idle   = (state_q == StIdle);
  assign if_win = if_req_valid_i && (!ls_req_valid_i || (starve_q == MaxWait));
  assign ls_win = ls_req_valid_i && !if_win;

  always_comb begin
    sel_eff    = '0;
    sel_wdata  = '0;
    sel_funct3 = 3'd2;
    sel_write  = 1'b0;
    sel_err    = 1'b0;
    if (if_win) begin
      sel_eff = if_req_addr_i;
      sel_err = if_range_bad;
    end else if (ls_win) begin
      sel_eff    = ls_eff;
      sel_wdata  = ls_req_wdata_i;
      sel_funct3 = ls_req_funct3_i;
      sel_write  = ls_req_write_i;
      sel_err    = ls_f3_bad | ls_range_bad;
    end
  end

  assign rsp_ready = owner_if_q ? if_rsp_ready_i : ls_rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      starve_q       <= '0;
      eff_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      funct3_q       <= '0;
      write_q        <= 1'b0;
      owner_if_q     <= 1'b0;
      err_q          <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (if_win || ls_win) begin
            owner_if_q <= if_win;
            eff_q      <= sel_eff;
            wdata_q    <= sel_wdata;
            funct3_q   <= sel_funct3;
            write_q    <= sel_write;
            err_q      <= sel_err;
            if (if_win) begin
              starve_q <= '0;
            end else if (if_req_valid_i && (starve_q != MaxWait)) begin
              starve_q <= starve_q + 4'd1;
            end
            if (sel_err) begin
              // Rejected accesses skip the memory entirely.
              rdata_q        <= '0;
              if_rsp_valid_q <= if_win;
              ls_rsp_valid_q <= ls_win;
              state_q        <= StResp;
            end else begin
              mem_read_q  <= !sel_write;
              mem_write_q <= sel_write;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= StCapture;
        end
        StCapture: begin
          rdata_q        <= write_q ? 32'h0 : mem_data_i;
          if_rsp_valid_q <= owner_if_q;
          ls_rsp_valid_q <= !owner_if_q;
          state_q        <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            if_rsp_valid_q <= 1'b0;
            ls_rsp_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_req_ready_o = idle && if_win;
  assign ls_req_ready_o = idle && ls_win;

  assign if_rsp_valid_o = if_rsp_valid_q;
  assign if_rsp_data_o  = if_rsp_valid_q ? rdata_q : 32'h0;
  assign if_rsp_err_o   = if_rsp_valid_q & err_q;
  assign ls_rsp_valid_o = ls_rsp_valid_q;
  assign ls_rsp_data_o  = ls_rsp_valid_q ? rdata_q : 32'h0;
  assign ls_rsp_err_o   = ls_rsp_valid_q & err_q;

  assign mem_addr_o   = eff_q;
  assign mem_offset_o = 12'h0;
  assign mem_value_o  = wdata_q;
  assign mem_funct3_o = funct3_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;

endmodule
